// File: rtl/k2red_arb.sv
// Round-robin arbiter that shares one fixed-latency K2RED reducer among NREQ requesters.
// Responses are tagged with the requester ID and returned in issue order through a credit-guarded FIFO.
module k2red_arb #(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned WID    = 24,
  parameter int unsigned WID2   = 12,
  parameter int unsigned LAT    = 5,
  parameter int unsigned FDEPTH = 8,
  parameter int unsigned IDW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*WID-1:0]  req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic [WID-1:0]       red_c,
  input  logic [WID2-1:0]      red_cred,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [WID2-1:0]      rsp_data,
  output logic [IDW-1:0]       rsp_id,
  output logic                 busy
);

  localparam int unsigned PW = (FDEPTH > 1) ? $clog2(FDEPTH) : 1;
  localparam int unsigned CW = $clog2(FDEPTH + 1);

  logic [IDW-1:0]  ptr_q, ptr_d, gnt_id, scan_idx;
  logic            gnt_found, can_issue, issue, push, pop;
  logic [CW-1:0]   outst_q, outst_d, fcnt_q, fcnt_d;
  logic [PW-1:0]   wptr_q, rptr_q;
  logic [LAT:0]    pv_q;
  logic [IDW-1:0]  pid_q [LAT+1];
  logic [WID-1:0]  opnd [NREQ];
  logic [WID2-1:0] mem_data_q [FDEPTH];
  logic [IDW-1:0]  mem_id_q [FDEPTH];

  always_comb begin
    for (int i = 0; i < int'(NREQ); i++) begin
      opnd[i] = req_data[i*WID +: WID];
    end
  end

  // Outstanding covers in-flight operands plus FIFO entries, so the FIFO can never overflow.
  assign can_issue = outst_q < CW'(FDEPTH);

  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    scan_idx  = '0;
    for (int k = 0; k < int'(NREQ); k++) begin
      scan_idx = IDW'((int'(ptr_q) + k) % int'(NREQ));
      if (!gnt_found && req_valid[scan_idx]) begin
        gnt_found = 1'b1;
        gnt_id    = scan_idx;
      end
    end
  end

  // Gated by rst so the grant output is quiet while reset is held.
  assign issue     = gnt_found & can_issue & rst;
  assign req_ready = issue ? (NREQ'(1) << gnt_id) : '0;

  always_comb begin
    ptr_d = ptr_q;
    if (issue) begin
      ptr_d = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);
    end
  end

  assign push      = pv_q[LAT];
  assign rsp_valid = fcnt_q != '0;
  assign pop       = rsp_valid & rsp_ready;
  assign rsp_data  = rsp_valid ? mem_data_q[rptr_q] : '0;
  assign rsp_id    = rsp_valid ? mem_id_q[rptr_q] : '0;
  assign busy      = outst_q != '0;
  assign outst_d   = outst_q + CW'(issue) - CW'(pop);
  assign fcnt_d    = fcnt_q + CW'(push) - CW'(pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q   <= '0;
      red_c   <= '0;
      pv_q    <= '0;
      outst_q <= '0;
      fcnt_q  <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      for (int k = 0; k <= int'(LAT); k++) begin
        pid_q[k] <= '0;
      end
    end else begin
      ptr_q    <= ptr_d;
      red_c    <= issue ? opnd[gnt_id] : '0;
      pv_q[0]  <= issue;
      pid_q[0] <= gnt_id;
      for (int k = 1; k <= int'(LAT); k++) begin
        pv_q[k]  <= pv_q[k-1];
        pid_q[k] <= pid_q[k-1];
      end
      outst_q <= outst_d;
      fcnt_q  <= fcnt_d;
      if (push) begin
        wptr_q <= (wptr_q == PW'(FDEPTH - 1)) ? '0 : wptr_q + PW'(1);
      end
      if (pop) begin
        rptr_q <= (rptr_q == PW'(FDEPTH - 1)) ? '0 : rptr_q + PW'(1);
      end
    end
  end

  // Storage needs no reset; occupancy is tracked by fcnt_q.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data_q[wptr_q] <= red_cred;
      mem_id_q[wptr_q]   <= pid_q[LAT];
    end
  end

endmodule

// File: tb/tb_k2red_arb.sv
// Self-checking bench for k2red_arb: fixed grant table, directed corner sequences and
// random traffic checked against a queue-based model of issue order and response timing.
module tb_k2red_arb;
  localparam int NREQ = 4, WID = 24, WID2 = 12, LAT = 5, FDEPTH = 8, IDW = 2;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [NREQ-1:0]     rv = '0;
  logic [NREQ*WID-1:0] rd = '0;
  logic                rr = 1'b0;
  logic [NREQ-1:0]     req_ready;
  logic [WID-1:0]      red_c;
  logic [WID2-1:0]     red_cred;
  logic                rsp_valid;
  logic [WID2-1:0]     rsp_data;
  logic [IDW-1:0]      rsp_id;
  logic                busy;

  always #5 clk = ~clk;

  k2red_arb #(.NREQ(NREQ), .WID(WID), .WID2(WID2), .LAT(LAT), .FDEPTH(FDEPTH)) dut (
    .clk(clk), .rst(rst), .req_valid(rv), .req_data(rd), .req_ready(req_ready),
    .red_c(red_c), .red_cred(red_cred), .rsp_valid(rsp_valid), .rsp_ready(rr),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy)
  );

  // Stub reducer: LAT-stage delay of c[11:0] ^ 12'hA5A.
  logic [WID2-1:0] stub_q [LAT];
  always_ff @(posedge clk) begin
    stub_q[0] <= red_c[11:0] ^ 12'hA5A;
    for (int k = 1; k < LAT; k++) stub_q[k] <= stub_q[k-1];
  end
  assign red_cred = stub_q[LAT-1];

  typedef struct {int id; int data; int cyc;} rsp_t;
  typedef struct {logic [3:0] rv; logic [3:0] exp;} vec_t;

  rsp_t sent[$];
  int ptr, cyc, exp_redc, dut_occ, hs_cnt, nchk, nerr;
  logic last_v, last_busy;
  logic [3:0] last_rdy;
  logic [WID-1:0] last_redc;

  task automatic chk(string name, int act, int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    sent.delete();
    ptr = 0; cyc = 0; exp_redc = 0; dut_occ = 0;
  endtask

  // One cycle: compare outputs at negedge against the model, advance model, move to posedge+1.
  task automatic step();
    int g, idx;
    logic ev, hs, pp;
    rsp_t e;
    @(negedge clk);
    g = -1;
    if (sent.size() < FDEPTH) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = (ptr + k) % NREQ;
        if (g < 0 && rv[idx]) g = idx;
      end
    end
    chk("req_ready", int'(req_ready), (g >= 0) ? (1 << g) : 0);
    chk("red_c", int'(red_c), exp_redc);
    chk("busy", int'(busy), int'(sent.size() != 0));
    ev = (sent.size() > 0) && (cyc >= sent[0].cyc + LAT + 2);
    chk("rsp_valid", int'(rsp_valid), int'(ev));
    if (ev) begin
      chk("rsp_id", int'(rsp_id), sent[0].id);
      chk("rsp_data", int'(rsp_data), sent[0].data);
    end
    last_v = rsp_valid; last_busy = busy; last_rdy = req_ready; last_redc = red_c;
    hs = |(rv & req_ready);
    pp = rsp_valid & rr;
    if (hs) hs_cnt++;
    dut_occ += int'(hs) - int'(pp);
    nchk++;
    if (dut_occ > FDEPTH || dut_occ < 0) begin
      nerr++;
      $display("FAIL occupancy: got %0d expected 0..%0d", dut_occ, FDEPTH);
    end
    if (ev && rr) void'(sent.pop_front());
    if (g >= 0) begin
      e.id = g;
      e.data = int'(rd[g*WID +: 12]) ^ 'hA5A;
      e.cyc = cyc;
      sent.push_back(e);
      ptr = (g + 1) % NREQ;
      exp_redc = int'(rd[g*WID +: WID]);
    end else begin
      exp_redc = 0;
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic apply_reset();
    rv = '0; rr = 1'b0; rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
  endtask

  task automatic rand_data();
    for (int i = 0; i < NREQ; i++) rd[i*WID +: WID] = WID'($urandom);
  endtask

  task automatic drain(int n);
    rv = '0; rr = 1'b1;
    repeat (n) step();
  endtask

  task automatic single_req(int lane, int val, string tag);
    int first;
    first = -1;
    rr = 1'b1; rv = '0; rd = '0;
    rv[lane] = 1'b1;
    rd[lane*WID +: WID] = WID'(val);
    step();
    rv = '0;
    for (int n = 1; n <= 12; n++) begin
      step();
      if (n == 1) begin
        chk({tag, "_red_c"}, int'(last_redc), val);
        chk({tag, "_busy_c1"}, int'(last_busy), 1);
      end
      if (n == 8) chk({tag, "_busy_c8"}, int'(last_busy), 0);
      if (last_v && first < 0) first = n;
    end
    chk({tag, "_latency"}, first, LAT + 2);
  endtask

  vec_t tbl[10];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int nv;
    nchk = 0; nerr = 0; hs_cnt = 0;
    model_reset();
    tbl[0] = '{4'b0001, 4'b0001}; tbl[1] = '{4'b1001, 4'b1000};
    tbl[2] = '{4'b1001, 4'b0001}; tbl[3] = '{4'b1001, 4'b1000};
    tbl[4] = '{4'b0000, 4'b0000}; tbl[5] = '{4'b0110, 4'b0010};
    tbl[6] = '{4'b0111, 4'b0100}; tbl[7] = '{4'b0011, 4'b0001};
    tbl[8] = '{4'b1110, 4'b0010}; tbl[9] = '{4'b1011, 4'b1000};

    rst = 1'b0;
    #2;
    chk("reset_ready", int'(req_ready), 0);
    chk("reset_rsp_valid", int'(rsp_valid), 0);
    chk("reset_busy", int'(busy), 0);
    apply_reset();

    // Grant table, including wrap and skip with ptr = 1.
    rr = 1'b1;
    for (int i = 0; i < 10; i++) begin
      rv = tbl[i].rv;
      rand_data();
      #3;
      chk($sformatf("tbl_grant%0d", i), int'(req_ready), int'(tbl[i].exp));
      step();
    end
    drain(12);

    single_req(2, 453, "single");

    // Fairness with every requester active.
    rv = 4'b1111; rr = 1'b1;
    for (int i = 0; i < 20; i++) begin rand_data(); step(); end
    drain(12);

    // Backpressure: exactly FDEPTH issues, then resume with pops every cycle.
    rr = 1'b0; rv = 4'b1111; hs_cnt = 0;
    for (int i = 0; i < 16; i++) begin rand_data(); step(); end
    chk("bp_issues", hs_cnt, FDEPTH);
    chk("bp_ready_low", int'(last_rdy), 0);
    chk("bp_fifo_head", int'(last_v), 1);
    rr = 1'b1;
    for (int i = 0; i < 30; i++) begin rand_data(); step(); end
    drain(12);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      rv = 4'($urandom_range(0, 15));
      rr = ($urandom_range(0, 3) != 0);
      rand_data();
      step();
    end
    drain(20);

    // Reset mid-flight: 2 buffered, 3 in flight.
    rr = 1'b0; rv = 4'b1111;
    for (int i = 0; i < 5; i++) begin rand_data(); step(); end
    rv = '0;
    repeat (3) step();
    chk("pre_rst_valid", int'(rsp_valid), 1);
    rv = 4'b1111;
    #2 rst = 1'b0;
    #1;
    chk("arst_ready", int'(req_ready), 0);
    chk("arst_red_c", int'(red_c), 0);
    chk("arst_rsp_valid", int'(rsp_valid), 0);
    chk("arst_rsp_data", int'(rsp_data), 0);
    chk("arst_rsp_id", int'(rsp_id), 0);
    chk("arst_busy", int'(busy), 0);
    rv = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    rr = 1'b1; nv = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (last_v) nv++;
    end
    chk("post_rst_spurious", nv, 0);
    single_req(1, 24'h00ABCD, "post_rst");
    drain(4);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
